fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding + load-use hazard unit for the 5-stage pipeline.
//  Compares the decode-stage sources against the ID/EX and EX/MEM destinations.
//  Registers each source's forward select so it is valid while that instruction is in EX.
//  Runs a stall FSM for load-use hazards, with configurable load latency, and a saturating stall counter.
// PARAMETERS
//  NUM_SRC   2   source operands per instruction
//  ADDR_W    5   register address width
//  LOAD_LAT  1   stall cycles per load-use hazard (>=1)
//  CNT_W     16  width of stall_cnt performance counter
// PORTS
//  clk              in   1              clock, all state updates on posedge
//  rst_n            in   1              asynchronous active-low reset
//  id_src_addr      in   NUM_SRC*ADDR_W ID-stage source regs; src i at [i*ADDR_W +: ADDR_W]
//  id_src_used      in   NUM_SRC        1 = source i is actually read
//  id_valid         in   1              ID holds a real instruction
//  idex_reg_write   in   1              ID/EX instruction writes a register
//  idex_mem_read    in   1              ID/EX instruction is a load
//  idex_rd          in   ADDR_W         ID/EX destination
//  exmem_reg_write  in   1              EX/MEM instruction writes a register
//  exmem_rd         in   ADDR_W         EX/MEM destination
//  flush            in   1              branch/exception flush of IF/ID and ID/EX
//  forward_sel      out  2*NUM_SRC      registered per-source select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  stall            out  1              hold PC and IF/ID
//  bubble           out  1              load a NOP into ID/EX
//  stall_cnt        out  CNT_W          saturating count of stall cycles
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, cnt=0, forward_sel=0, stall_cnt=0; stall=bubble=0.
//  Source i is live when id_valid & id_src_used[i] & src!=0. Register 0 never forwards and never stalls.
//  Next-cycle select, computed combinationally per live source:
//   - idex_reg_write & idex_rd==src gives 10, because that producer will be in EX/MEM.
//   - else exmem_reg_write & exmem_rd==src gives 01, because that producer will be in MEM/WB.
//   - else 00. The newer producer always wins.
//  Load-use detect: idex_mem_read & idex_reg_write & idex_rd!=0 & idex_rd matches any live source.
//  FSM: IDLE, STALL. cnt is a down-counter of width clog2(LOAD_LAT+1).
//   IDLE:  detect & !flush -> stall=1. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1; else stay IDLE.
//   STALL: stall=1. cnt decrements each cycle; on cnt==1 go to IDLE.
//          Detect is ignored in STALL; the counter governs.
//  Total stall per hazard = LOAD_LAT consecutive cycles. bubble == stall.
//  forward_sel update on posedge:
//   - 0 if stall|flush, because EX will hold a bubble next cycle.
//   - else the computed select.
//  Recomputation every cycle against live ID/EX, EX/MEM contents resolves the post-stall select.
//   With LOAD_LAT=1 the load sits in EX/MEM during the stall, so the consumer gets 01.
//  flush: overrides everything same cycle. stall=bubble=0, state->IDLE, cnt->0, forward_sel->0.
//   Flush in the same cycle as detect: flush wins, no stall.
//  stall_cnt increments on every cycle with stall=1 and saturates at all-ones (no wrap).
//  Reset mid-stall: immediate return to reset values; stall drops asynchronously.
//  Two sources matching different producers are resolved independently.
// TESTING
//  1. rst_n=0 mid-STALL (LOAD_LAT=3) -> stall, forward_sel, stall_cnt all 0 immediately; IDLE after release.
//  2. EX/MEM rd=5 and ID/EX rd=5, both reg_write, src0=5 live ->
//     forward_sel[1:0]=10 next cycle (newest wins).
//     Repeat with ID/EX rd=7 -> 01.
//  3. Load rd=8 in ID/EX, src1=8 live, LOAD_LAT=1 -> stall=bubble=1 for exactly 1 cycle, forward_sel=0.
//     Next cycle forward_sel[3:2]=01.
//  4. LOAD_LAT=3, same load-use -> stall high 3 consecutive cycles, stall_cnt +3.
//     Second hazard after: +3 again; preset stall_cnt=16'hFFFE -> saturates at 16'hFFFF.
//  5. Detect and flush in same cycle -> no stall; flush during STALL cycle 2 -> stall=0 that cycle, IDLE.
//  6. Sources equal to rd=0 with reg_write=1, or id_src_used=0 with match ->
//     forward_sel=00, no stall.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit for the 5-stage pipeline.
// Forward selects are registered so they are valid while the consumer sits in EX.
module fwd_hazard_unit #(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_valid,
  input  logic                      idex_reg_write,
  input  logic                      idex_mem_read,
  input  logic [ADDR_W-1:0]         idex_rd,
  input  logic                      exmem_reg_write,
  input  logic [ADDR_W-1:0]         exmem_rd,
  input  logic                      flush,
  output logic [2*NUM_SRC-1:0]      forward_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned CW = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE,
    STALL
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [NUM_SRC-1:0]     live;
  logic [2*NUM_SRC-1:0]   fwd_next;
  logic                   src_match;
  logic                   detect;
  logic                   stall_int;

  // Per-source select; the ID/EX producer is newer, so it is tested first.
  always_comb begin
    live      = '0;
    fwd_next  = '0;
    src_match = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      live[i] = id_valid & id_src_used[i] &
                (id_src_addr[i*ADDR_W +: ADDR_W] != '0);
      if (live[i]) begin
        if (idex_reg_write && (idex_rd == id_src_addr[i*ADDR_W +: ADDR_W]))
          fwd_next[2*i +: 2] = 2'b10;
        else if (exmem_reg_write && (exmem_rd == id_src_addr[i*ADDR_W +: ADDR_W]))
          fwd_next[2*i +: 2] = 2'b01;
        if (idex_rd == id_src_addr[i*ADDR_W +: ADDR_W])
          src_match = 1'b1;
      end
    end
    detect = idex_mem_read & idex_reg_write & (idex_rd != '0) & src_match;
  end

  // Gated by rst_n so stall drops immediately on an asynchronous reset.
  always_comb begin
    stall_int = 1'b0;
    if (rst_n && !flush) begin
      if (state == STALL)
        stall_int = 1'b1;
      else
        stall_int = detect;
    end
  end

  assign stall  = stall_int;
  assign bubble = stall_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      forward_sel <= '0;
    end else if (flush) begin
      state       <= IDLE;
      cnt         <= '0;
      forward_sel <= '0;
    end else begin
      forward_sel <= stall_int ? '0 : fwd_next;
      case (state)
        IDLE: begin
          if (detect && (LOAD_LAT > 1)) begin
            state <= STALL;
            cnt   <= CNT_INIT;
          end
        end
        STALL: begin
          if (cnt == CNT_ONE) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_int && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed-vector bench for fwd_hazard_unit: one LOAD_LAT=1 instance, one LOAD_LAT=3
// instance, and a narrow-counter LOAD_LAT=3 instance for saturation.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic        id_valid;
  logic        idex_reg_write;
  logic        idex_mem_read;
  logic [4:0]  idex_rd;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic        flush;

  logic [3:0]  fs1, fs3, fss;
  logic        st1, st3, sts;
  logic        bb1, bb3, bbs;
  logic [15:0] sc1, sc3;
  logic [1:0]  scs;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NUM_SRC(2), .ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_valid(id_valid), .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
    .idex_rd(idex_rd), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .flush(flush), .forward_sel(fs1), .stall(st1), .bubble(bb1), .stall_cnt(sc1));

  fwd_hazard_unit #(.NUM_SRC(2), .ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_valid(id_valid), .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
    .idex_rd(idex_rd), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .flush(flush), .forward_sel(fs3), .stall(st3), .bubble(bb3), .stall_cnt(sc3));

  fwd_hazard_unit #(.NUM_SRC(2), .ADDR_W(5), .LOAD_LAT(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_valid(id_valid), .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
    .idex_rd(idex_rd), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .flush(flush), .forward_sel(fss), .stall(sts), .bubble(bbs), .stall_cnt(scs));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_src_addr     = '0;
    id_src_used     = '0;
    id_valid        = 1'b0;
    idex_reg_write  = 1'b0;
    idex_mem_read   = 1'b0;
    idex_rd         = '0;
    exmem_reg_write = 1'b0;
    exmem_rd        = '0;
    flush           = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Load in ID/EX writing r8, consumer reads r8 as source 1.
  task automatic load_use();
    id_valid       = 1'b1;
    id_src_addr    = {5'd8, 5'd3};
    id_src_used    = 2'b10;
    idex_reg_write = 1'b1;
    idex_mem_read  = 1'b1;
    idex_rd        = 5'd8;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #2;
    check("rst_stall", {31'd0, st3}, 32'd0);
    check("rst_bubble", {31'd0, bb3}, 32'd0);
    check("rst_fsel", {28'd0, fs1}, 32'd0);
    check("rst_cnt", {16'd0, sc1}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;

    // Reset asserted while u_lat3 is in STALL.
    load_use();
    #1;
    check("t1_stall_pre", {31'd0, st3}, 32'd1);
    tick();
    check("t1_stall_in_stall", {31'd0, st3}, 32'd1);
    check("t1_cnt_pre", {16'd0, sc3}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_async_stall", {31'd0, st3}, 32'd0);
    check("t1_async_fsel", {28'd0, fs3}, 32'd0);
    check("t1_async_cnt", {16'd0, sc3}, 32'd0);
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_idle_after", {31'd0, st3}, 32'd0);
    check("t1_cnt_after", {16'd0, sc3}, 32'd0);

    // Forward priority: newest producer wins.
    do_reset();
    id_valid        = 1'b1;
    id_src_addr     = {5'd0, 5'd5};
    id_src_used     = 2'b01;
    idex_reg_write  = 1'b1;
    idex_rd         = 5'd5;
    exmem_reg_write = 1'b1;
    exmem_rd        = 5'd5;
    tick();
    check("t2_newest", {28'd0, fs1}, 32'b0010);
    idex_rd = 5'd7;
    tick();
    check("t2_exmem", {28'd0, fs1}, 32'b0001);
    id_src_addr = {5'd7, 5'd5};
    id_src_used = 2'b11;
    tick();
    check("t2_two_src", {28'd0, fs1}, 32'b1001);
    check("t2_no_stall", {31'd0, st1}, 32'd0);

    // Load-use with LOAD_LAT=1.
    do_reset();
    load_use();
    #1;
    check("t3_stall", {31'd0, st1}, 32'd1);
    check("t3_bubble", {31'd0, bb1}, 32'd1);
    tick();
    check("t3_fsel_zero", {28'd0, fs1}, 32'd0);
    check("t3_cnt", {16'd0, sc1}, 32'd1);
    idex_reg_write  = 1'b0;
    idex_mem_read   = 1'b0;
    idex_rd         = 5'd0;
    exmem_reg_write = 1'b1;
    exmem_rd        = 5'd8;
    #1;
    check("t3_stall_drop", {31'd0, st1}, 32'd0);
    tick();
    check("t3_post_fsel", {28'd0, fs1}, 32'b0100);
    check("t3_cnt_hold", {16'd0, sc1}, 32'd1);

    // LOAD_LAT=3: three stall cycles per hazard, detect ignored inside STALL.
    do_reset();
    for (int h = 0; h < 2; h++) begin
      load_use();
      for (int c = 0; c < 3; c++) begin
        #1;
        check($sformatf("t4_h%0d_stall_c%0d", h, c), {31'd0, st3}, 32'd1);
        check($sformatf("t4_h%0d_bubble_c%0d", h, c), {31'd0, bb3}, 32'd1);
        tick();
      end
      idex_reg_write = 1'b0;
      idex_mem_read  = 1'b0;
      idex_rd        = 5'd0;
      #1;
      check($sformatf("t4_h%0d_released", h), {31'd0, st3}, 32'd0);
      tick();
      check($sformatf("t4_h%0d_cnt", h), {16'd0, sc3}, 32'(3 * (h + 1)));
      check($sformatf("t4_h%0d_sat_cnt", h), {30'd0, scs}, 32'd3);
    end

    // Flush versus detect, and flush in the second stall cycle.
    do_reset();
    load_use();
    flush = 1'b1;
    #1;
    check("t5_flush_same_st3", {31'd0, st3}, 32'd0);
    check("t5_flush_same_st1", {31'd0, st1}, 32'd0);
    tick();
    clear_inputs();
    #1;
    check("t5_idle_after_flush", {31'd0, st3}, 32'd0);
    tick();
    check("t5_cnt_zero", {16'd0, sc3}, 32'd0);
    load_use();
    #1;
    check("t5_stall_c1", {31'd0, st3}, 32'd1);
    tick();
    flush = 1'b1;
    #1;
    check("t5_flush_c2", {31'd0, st3}, 32'd0);
    tick();
    clear_inputs();
    #1;
    check("t5_idle_c3", {31'd0, st3}, 32'd0);
    check("t5_fsel_flushed", {28'd0, fs3}, 32'd0);
    check("t5_cnt_one", {16'd0, sc3}, 32'd1);

    // Register 0 and unused sources never forward or stall.
    do_reset();
    id_valid        = 1'b1;
    id_src_addr     = {5'd0, 5'd0};
    id_src_used     = 2'b11;
    idex_reg_write  = 1'b1;
    idex_mem_read   = 1'b1;
    idex_rd         = 5'd0;
    exmem_reg_write = 1'b1;
    exmem_rd        = 5'd0;
    #1;
    check("t6_r0_stall", {31'd0, st1}, 32'd0);
    tick();
    check("t6_r0_fsel", {28'd0, fs1}, 32'd0);
    id_src_addr = {5'd9, 5'd9};
    id_src_used = 2'b00;
    idex_rd     = 5'd9;
    exmem_rd    = 5'd9;
    #1;
    check("t6_unused_stall", {31'd0, st3}, 32'd0);
    tick();
    check("t6_unused_fsel", {28'd0, fs1}, 32'd0);
    check("t6_cnt", {16'd0, sc1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
